// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory port arbiter slice.
package dm_pkg;

  // Access size encodings on the op inputs; 2'd0 is reserved and illegal.
  localparam logic [1:0] DM_OP_SB = 2'd1;
  localparam logic [1:0] DM_OP_SH = 2'd2;
  localparam logic [1:0] DM_OP_SW = 2'd3;

  // Arbiter sequencing: one issue cycle followed by one completion cycle.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } dm_state_e;

  // Requester identity as registered for the completion cycle.
  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } dm_port_e;

  // True when the size/offset pair can be served by one aligned word access.
  function automatic logic dm_access_legal(input logic [1:0] op, input logic [1:0] addr_lo);
    logic legal;
    legal = 1'b0;
    case (op)
      DM_OP_SB: legal = 1'b1;
      DM_OP_SH: legal = ~addr_lo[0];
      DM_OP_SW: legal = (addr_lo == 2'b00);
      default:  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/dm_lane_gen.sv
// Byte-lane enable and store-data replication for one memory access.
module dm_lane_gen
  import dm_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] lane_wdata_o,
  output logic        misalign_o
);

  // Decode the access size into lane enables and replicate the store data across lanes.
  always_comb begin
    byteen_o     = '0;
    lane_wdata_o = '0;
    case (op_i)
      DM_OP_SB: begin
        byteen_o     = 4'b0001 << addr_lo_i;
        lane_wdata_o = {4{wdata_i[7:0]}};
      end
      DM_OP_SH: begin
        byteen_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        lane_wdata_o = {2{wdata_i[15:0]}};
      end
      DM_OP_SW: begin
        byteen_o     = 4'b1111;
        lane_wdata_o = wdata_i;
      end
      default: begin
        byteen_o     = '0;
        lane_wdata_o = '0;
      end
    endcase
    misalign_o = ~dm_access_legal(op_i, addr_lo_i);
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter in front of the single-port data memory.
// Port 0 (CPU MEM stage) has priority; port 1 (DMA/loader) is forced through
// after STARVE_LIMIT consecutive denials.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [1:0]        op0,
  input  logic [1:0]        op1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_byteen,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned       CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

  dm_state_e        state_q, state_d;
  dm_port_e         owner_q, owner_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic             idle;
  logic             busy;
  logic             issue;
  logic             win1;
  logic             sel_we;
  logic [1:0]       sel_op;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wd;
  logic             lane_mis;
  logic             load_ok;
  logic             unused_addr_hi;

  // Pick this cycle's winner and route its fields to the lane generator.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    busy      = (state_q == ST_BUSY);
    // reset is folded in so the memory interface stays quiet while reset is held
    issue     = idle && !reset && (req0 || req1);
    win1      = req1 && (!req0 || (starve_q == STARVE_MAX));
    sel_we    = win1 ? we1    : we0;
    sel_op    = win1 ? op1    : op0;
    sel_addr  = win1 ? addr1  : addr0;
    sel_wdata = win1 ? wdata1 : wdata0;
    unused_addr_hi = ^sel_addr[31:MEM_AW+2];
  end

  dm_lane_gen u_lane_gen (
    .op_i         (sel_op),
    .addr_lo_i    (sel_addr[1:0]),
    .wdata_i      (sel_wdata),
    .byteen_o     (lane_be),
    .lane_wdata_o (lane_wd),
    .misalign_o   (lane_mis)
  );

  // Next-state logic: issue in IDLE, complete in BUSY, capture the winner's attributes on issue.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    err_d    = err_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_BUSY;
          owner_d = win1 ? PORT_DMA : PORT_CPU;
          we_d    = sel_we;
          err_d   = lane_mis;
        end
        if (!reset) begin
          if (!req1 || win1) begin
            starve_d = '0;
          end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      ST_BUSY: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, owner and starvation registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= PORT_CPU;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  // Memory interface is live only on a legal issue; everything else reads as zero.
  always_comb begin
    mem_en     = issue && !lane_mis;
    mem_we     = mem_en && sel_we;
    mem_byteen = mem_en ? lane_be : '0;
    mem_addr   = mem_en ? sel_addr[MEM_AW+1:2] : '0;
    mem_wdata  = mem_en ? lane_wd : '0;
  end

  // Completion return: ack and err to the owner, raw memory word on legal loads.
  always_comb begin
    load_ok = busy && !we_q && !err_q;
    ack0    = busy && (owner_q == PORT_CPU);
    ack1    = busy && (owner_q == PORT_DMA);
    err0    = ack0 && err_q;
    err1    = ack1 && err_q;
    rdata0  = (load_ok && (owner_q == PORT_CPU)) ? mem_rdata : '0;
    rdata1  = (load_ok && (owner_q == PORT_DMA)) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter with a behavioural memory behind it.
module tb_dm_port_arbiter;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [3:0]  mem_byteen;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.MEM_AW(10), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .op0(op0), .op1(op1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byteen(mem_byteen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural synchronous memory: byte-masked write, registered read.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_en) begin
      w = mem[mem_addr];
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteen[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
        mem[mem_addr] <= w;
      end
      mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Completion monitor: every ack pops the scoreboard and is checked for port, timing, err and data.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack0 || ack1) begin
        chk("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
        chk("idle_port_rdata", ack0 ? rdata1 : rdata0, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_port", ack1 ? 32'd1 : 32'd0, mon_e.port);
          chk("ack_cycle", cyc, mon_e.at);
          chk("ack_err", {31'd0, ack1 ? err1 : err0}, {31'd0, mon_e.err});
          chk("ack_rdata", ack1 ? rdata1 : rdata0, mon_e.rdata);
        end
      end else if (sb.size() > 0 && sb[0].at < cyc) begin
        mon_e = sb.pop_front();
        chk("ack_missing", cyc, mon_e.at);
      end
    end
  end

  typedef struct {
    int          port;
    logic        we;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic        mwe;
    logic [3:0]  be;
    logic [9:0]  maddr;
    logic [31:0] mwd;
    logic        err;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[14];

  task automatic drive(input vec_t v);
    if (v.port == 0) begin
      req0 = 1'b1; we0 = v.we; op0 = v.op; addr0 = v.addr; wdata0 = v.wdata;
    end else begin
      req1 = 1'b1; we1 = v.we; op1 = v.op; addr1 = v.addr; wdata1 = v.wdata;
    end
  endtask

  task automatic chk_issue(input vec_t v);
    chk("issue_en", {31'd0, mem_en}, {31'd0, v.en});
    chk("issue_we", {31'd0, mem_we}, {31'd0, v.mwe});
    chk("issue_byteen", {28'd0, mem_byteen}, {28'd0, v.be});
    chk("issue_addr", {22'd0, mem_addr}, {22'd0, v.maddr});
    chk("issue_wdata", mem_wdata, v.mwd);
  endtask

  // Single transfer on one port: issue-cycle check, scoreboard push, bounded wait for ack, release.
  task automatic xfer(input vec_t v);
    logic got;
    @(negedge clk);
    drive(v);
    #1;
    chk_issue(v);
    sb.push_back('{v.port, v.err, v.rdata, cyc + 1});
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (v.port == 0 ? ack0 : ack1) got = 1'b1;
    end
    chk("xfer_done", {31'd0, got}, 32'd1);
    if (v.port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  int base;
  int n0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    //          port we  op        addr           wdata          en mwe be       maddr    mwd            err rdata
    vecs[0]  = '{0, 1'b1, DM_OP_SB, 32'h00000013, 32'h000000AB, 1'b1, 1'b1, 4'b1000, 10'd4,   32'hABABABAB, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b1, DM_OP_SH, 32'h00000022, 32'h00001234, 1'b1, 1'b1, 4'b1100, 10'd8,   32'h12341234, 1'b0, 32'h0};
    vecs[2]  = '{1, 1'b0, DM_OP_SW, 32'h00000020, 32'h00000000, 1'b1, 1'b0, 4'b1111, 10'd8,   32'h00000000, 1'b0, 32'h12340000};
    vecs[3]  = '{0, 1'b1, DM_OP_SW, 32'h00000006, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0000, 10'd0,   32'h00000000, 1'b1, 32'h0};
    vecs[4]  = '{0, 1'b0, 2'd0,     32'h00000000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 10'd0,   32'h00000000, 1'b1, 32'h0};
    vecs[5]  = '{0, 1'b1, DM_OP_SH, 32'h00000021, 32'h00005555, 1'b0, 1'b0, 4'b0000, 10'd0,   32'h00000000, 1'b1, 32'h0};
    vecs[6]  = '{0, 1'b1, DM_OP_SB, 32'h00000010, 32'h0000005A, 1'b1, 1'b1, 4'b0001, 10'd4,   32'h5A5A5A5A, 1'b0, 32'h0};
    vecs[7]  = '{0, 1'b0, DM_OP_SB, 32'h00000013, 32'h00000000, 1'b1, 1'b0, 4'b1000, 10'd4,   32'h00000000, 1'b0, 32'hAB00005A};
    vecs[8]  = '{0, 1'b1, DM_OP_SW, 32'h000003FC, 32'hDEADBEEF, 1'b1, 1'b1, 4'b1111, 10'd255, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[9]  = '{1, 1'b0, DM_OP_SW, 32'h000003FC, 32'h00000000, 1'b1, 1'b0, 4'b1111, 10'd255, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[10] = '{0, 1'b1, DM_OP_SW, 32'h00000FFC, 32'hCAFEF00D, 1'b1, 1'b1, 4'b1111, 10'd1023, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[11] = '{0, 1'b0, DM_OP_SH, 32'h00000002, 32'h00000000, 1'b1, 1'b0, 4'b1100, 10'd0,   32'h00000000, 1'b0, 32'h0};
    vecs[12] = '{0, 1'b1, DM_OP_SW, 32'h10000004, 32'h11223344, 1'b1, 1'b1, 4'b1111, 10'd1,   32'h11223344, 1'b0, 32'h0};
    vecs[13] = '{0, 1'b0, DM_OP_SW, 32'h00000004, 32'h00000000, 1'b1, 1'b0, 4'b1111, 10'd1,   32'h00000000, 1'b0, 32'h11223344};

    // Held reset: outputs quiet even with a request present.
    req0 = 1'b1; we0 = 1'b1; op0 = DM_OP_SW; addr0 = 32'h0; wdata0 = 32'h1;
    repeat (2) @(negedge clk);
    chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
    chk("reset_acks", {30'd0, ack1, ack0}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_state", {31'd0, dut.state_q}, {31'd0, ST_IDLE});
    chk("reset_starve", {29'd0, dut.starve_q}, 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) xfer(vecs[i]);

    // Reset mid-BUSY abandons the transfer without an ack.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; op0 = DM_OP_SW; addr0 = 32'h40; wdata0 = 32'h600DCAFE;
    #1;
    chk("rst_issue_en", {31'd0, mem_en}, 32'd1);
    @(posedge clk);
    #2;
    chk("rst_busy_ack0", {31'd0, ack0}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_ack0", {31'd0, ack0}, 32'd0);
    @(negedge clk);
    chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_state", {31'd0, dut.state_q}, {31'd0, ST_IDLE});
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Simultaneous requests: port 0 first, port 1 two cycles later.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; op0 = DM_OP_SB; addr0 = 32'h50; wdata0 = 32'h77;
    req1 = 1'b1; we1 = 1'b0; op1 = DM_OP_SW; addr1 = 32'h20; wdata1 = 32'h0;
    #1;
    chk("both_issue_be", {28'd0, mem_byteen}, 32'h1);
    chk("both_issue_addr", {22'd0, mem_addr}, 32'd20);
    chk("both_issue_wdata", mem_wdata, 32'h77777777);
    sb.push_back('{0, 1'b0, 32'h0, cyc + 1});
    sb.push_back('{1, 1'b0, 32'h12340000, cyc + 3});
    for (int k = 0; k < 8 && (req0 || req1); k++) begin
      @(negedge clk);
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    chk("both_done", {30'd0, req1, req0}, 32'd0);

    // Starvation: port 0 held continuously; port 1 forced through after 4 denials.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; op0 = DM_OP_SW; addr0 = 32'h44; wdata0 = 32'h0BADF00D;
    req1 = 1'b1; we1 = 1'b0; op1 = DM_OP_SW; addr1 = 32'h20; wdata1 = 32'h0;
    #1;
    chk("starve_first_we", {31'd0, mem_we}, 32'd1);
    base = cyc;
    for (int k = 0; k < 4; k++) sb.push_back('{0, 1'b0, 32'h0, base + 1 + 2 * k});
    sb.push_back('{1, 1'b0, 32'h12340000, base + 9});
    sb.push_back('{0, 1'b0, 32'h0, base + 11});
    n0 = 0;
    for (int k = 0; k < 20 && (req0 || req1); k++) begin
      @(negedge clk);
      if (ack1) begin
        chk("starve_p0_wins_before_p1", n0, 32'd4);
        chk("starve_cnt_after_p1", {29'd0, dut.starve_q}, 32'd0);
        req1 = 1'b0;
      end
      if (ack0) begin
        n0++;
        if (n0 <= 4) begin
          chk("starve_cnt", {29'd0, dut.starve_q}, n0);
        end else begin
          chk("starve_cnt_end", {29'd0, dut.starve_q}, 32'd0);
          req0 = 1'b0;
        end
      end
    end
    chk("starve_done", {30'd0, req1, req0}, 32'd0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
